// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the interval timer controller.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_counter.sv
// Free-running up counter with async active-low clear, sync active-low clear and enable.
module timer_ctrl_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         sclr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_q <= '0;
    end else if (!sclr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/timer_ctrl.sv
// Prescaled interval timer: IDLE/RUN/DONE FSM, interval counter and start-time latches.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int W  = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [W-1:0]  period,
  input  logic [PW-1:0] prescale,
  output logic          busy,
  output logic          tick,
  output logic          done,
  output logic [W-1:0]  count
);

  state_t        r_state;
  logic          r_mode;
  logic [W-1:0]  r_period;
  logic [PW-1:0] r_prescale;
  logic [W-1:0]  r_count;
  logic          r_busy;
  logic          r_tick;
  logic          r_done;

  state_t        w_next_state;
  logic [W-1:0]  w_next_count;
  logic          w_latch;
  logic          w_next_tick;
  logic          w_run;
  logic [PW-1:0] w_presc;
  logic          w_ptick;
  logic          w_expiry;
  logic          w_presc_clrn;
  logic          w_presc_sclr;

  assign w_run    = (r_state == RUN);
  assign w_ptick  = w_run && (w_presc == r_prescale);
  assign w_expiry = w_ptick && (r_count == r_period);

  // Prescaler sits at zero outside RUN, so every run starts from a cleared divider.
  assign w_presc_clrn = ~clr;
  assign w_presc_sclr = ~(w_ptick | ~w_run);

  timer_ctrl_counter #(
    .W (PW)
  ) u_prescaler (
    .clk  (clk),
    .clrn (w_presc_clrn),
    .sclr (w_presc_sclr),
    .en   (w_run),
    .q    (w_presc)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_latch      = 1'b0;
    w_next_tick  = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (stop) begin
          w_next_state = IDLE;
          w_next_count = '0;
        end else if (start) begin
          w_next_state = RUN;
          w_next_count = '0;
          w_latch      = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          w_next_state = IDLE;
          w_next_count = '0;
        end else if (w_expiry) begin
          w_next_count = '0;
          w_next_tick  = 1'b1;
          w_next_state = (r_mode == MODE_PERIODIC) ? RUN : DONE;
        end else if (w_ptick) begin
          w_next_count = r_count + 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_count = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= IDLE;
      r_mode     <= MODE_ONESHOT;
      r_period   <= '0;
      r_prescale <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_tick  <= w_next_tick;
      r_busy  <= (w_next_state == RUN);
      r_done  <= (w_next_state == DONE);
      if (w_latch) begin
        r_mode     <= mode;
        r_period   <= period;
        r_prescale <= prescale;
      end
    end
  end

  assign busy  = r_busy;
  assign tick  = r_tick;
  assign done  = r_done;
  assign count = r_count;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: expected tick cycles are queued at start and popped as ticks appear.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  localparam int W  = 12;
  localparam int PW = 8;

  logic          clk      = 1'b0;
  logic          clr      = 1'b1;
  logic          start    = 1'b0;
  logic          stop     = 1'b0;
  logic          mode     = 1'b0;
  logic [W-1:0]  period   = '0;
  logic [PW-1:0] prescale = '0;
  logic          busy;
  logic          tick;
  logic          done;
  logic [W-1:0]  count;

  int cyc      = 0;
  int t0       = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  timer_ctrl #(
    .W  (W),
    .PW (PW)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .prescale (prescale),
    .busy     (busy),
    .tick     (tick),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d of run)", tag, got, exp, cyc - t0);
  endtask

  // Tick scoreboard: every observed tick must match the next queued cycle number.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      if (exp_q.size() == 0) check("tick_spurious", tick, 1'b0);
      else check("tick_cycle", cyc - t0, exp_q.pop_front());
    end
  end

  task automatic go(input int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic do_start(input logic m, input logic [W-1:0] p, input logic [PW-1:0] ps);
    mode     = m;
    period   = p;
    prescale = ps;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  int per_seq[5] = '{0, 0, 1, 1, 0};

  initial begin
    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // One-shot: period 3, prescale 0 -> tick in cycle 5
    do_start(MODE_ONESHOT, 12'd3, 8'd0);
    exp_q.push_back(5);
    check("os_busy_c1", busy, 1);
    check("os_count_c1", count, 0);
    go(4);
    check("os_busy_c4", busy, 1);
    check("os_done_c4", done, 0);
    check("os_count_c4", count, 3);
    go(5);
    check("os_busy_c5", busy, 0);
    check("os_done_c5", done, 1);
    check("os_count_c5", count, 0);
    go(8);
    check("os_done_c8", done, 1);
    check("os_tick_c8", tick, 0);
    check("os_q_empty", exp_q.size(), 0);

    // Restart from DONE into periodic: period 1, prescale 1 -> ticks 5, 9, 13
    do_start(MODE_PERIODIC, 12'd1, 8'd1);
    exp_q.push_back(5);
    exp_q.push_back(9);
    exp_q.push_back(13);
    check("rs_busy_c1", busy, 1);
    check("rs_done_c1", done, 0);
    for (int i = 0; i < 5; i++) begin
      go(i + 1);
      check("per_count", count, per_seq[i]);
    end
    go(6);
    // Start and new settings while running must be ignored
    mode     = MODE_ONESHOT;
    period   = 12'd7;
    prescale = 8'd0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    go(14);
    pulse_stop();
    check("per_stop_busy", busy, 0);
    check("per_stop_done", done, 0);
    check("per_stop_count", count, 0);
    check("per_q_empty", exp_q.size(), 0);

    // start and stop together in IDLE, then stop alone in IDLE
    start = 1'b1;
    stop  = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy_c1", busy, 0);
    check("ss_done_c1", done, 0);
    go(4);
    check("ss_busy_c4", busy, 0);
    check("ss_count_c4", count, 0);
    pulse_stop();
    check("idle_stop_busy", busy, 0);

    // period 0: tick every cycle from cycle 2; stop on the expiry in cycle 9
    do_start(MODE_PERIODIC, 12'd0, 8'd0);
    for (int k = 2; k <= 9; k++) exp_q.push_back(k);
    go(9);
    pulse_stop();
    check("p0_stop_busy", busy, 0);
    check("p0_stop_tick", tick, 0);
    check("p0_stop_count", count, 0);
    go(12);
    check("p0_q_empty", exp_q.size(), 0);

    // clr mid-run with count = 2
    do_start(MODE_PERIODIC, 12'd5, 8'd2);
    go(8);
    check("clr_pre_count", count, 2);
    check("clr_pre_busy", busy, 1);
    #2 clr = 1'b1;
    #1;
    check("clr_busy", busy, 0);
    check("clr_tick", tick, 0);
    check("clr_done", done, 0);
    check("clr_count", count, 0);
    @(negedge clk);
    clr = 1'b0;
    go(22);
    check("clr_idle_busy", busy, 0);
    check("clr_idle_done", done, 0);

    // Fresh start after clr re-times from zero: period 2, prescale 1 -> tick in cycle 7
    do_start(MODE_ONESHOT, 12'd2, 8'd1);
    exp_q.push_back(7);
    go(3);
    check("rc_count_c3", count, 1);
    go(6);
    check("rc_busy_c6", busy, 1);
    check("rc_done_c6", done, 0);
    go(7);
    check("rc_done_c7", done, 1);
    check("rc_busy_c7", busy, 0);
    go(9);
    check("rc_q_empty", exp_q.size(), 0);

    // Full range: period 2^W-1, prescale 0 -> first tick in cycle 2^W+1
    do_start(MODE_PERIODIC, {W{1'b1}}, 8'd0);
    exp_q.push_back((1 << W) + 1);
    go(1 << W);
    check("fr_count_top", count, (1 << W) - 1);
    go((1 << W) + 1);
    check("fr_count_wrap", count, 0);
    check("fr_busy", busy, 1);
    pulse_stop();
    check("fr_stop_busy", busy, 0);
    go((1 << W) + 5);
    check("fr_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
